// File: rtl/uart_rx_if.sv
// Bus between the UART receiver and the core's MMU.
//   rx          serial input pin, asynchronous to clk, idles high
//   read_en     pop the FIFO head this cycle (MMU load strobe)
//   err_clear   clear frame_err and overrun
//   data        FIFO head, first-word-fall-through, 8'h00 when empty
//   data_valid  FIFO not empty
//   fifo_full   FIFO holds its full depth
//   frame_err   sticky: a stop bit was sampled low
//   overrun     sticky: a byte arrived while the FIFO was full and not popped
// master: the MMU/pin side that drives the bus. slave: the receiver.
interface uart_rx_if;
  logic       rx;
  logic       read_en;
  logic       err_clear;
  logic [7:0] data;
  logic       data_valid;
  logic       fifo_full;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rx, read_en, err_clear,
    input  data, data_valid, fifo_full, frame_err, overrun
  );

  modport slave (
    input  rx, read_en, err_clear,
    output data, data_valid, fifo_full, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a small first-word-fall-through receive FIFO.
//   clk_i   system clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus_io  uart_rx_if.slave: rx pin, read_en/err_clear strobes, FIFO head and status flags
// ClksPerBit must be >= 4; FifoDepth must be a power of two, >= 2.
module uart_rx #(
  parameter int unsigned ClksPerBit = 868,
  parameter int unsigned FifoDepth  = 4
) (
  input logic      clk_i,
  input logic      rst_ni,
  uart_rx_if.slave bus_io
);

  localparam int unsigned CntW = $clog2(ClksPerBit);
  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned OccW = $clog2(FifoDepth + 1);

  localparam logic [CntW-1:0] HalfCnt = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(ClksPerBit - 1);
  localparam logic [OccW-1:0] FullOcc = OccW'(FifoDepth);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Synchroniser and edge detect; all reset to the idle (high) line level.
  logic rx_meta_q, rx_s_q, rx_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bus_io.rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  state_e          state_q;
  logic [CntW-1:0] bit_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Only a high-to-low transition starts a frame, so a line held low never retriggers.
          if (rx_prev_q && !rx_s_q) begin
            state_q   <= StStart;
            bit_cnt_q <= '0;
          end
        end
        StStart: begin
          if (bit_cnt_q == HalfCnt) begin
            if (!rx_s_q) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
              bit_idx_q <= '0;
            end else begin
              state_q <= StIdle;  // glitch shorter than half a bit
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        StData: begin
          if (bit_cnt_q == LastCnt) begin
            shift_q   <= {rx_s_q, shift_q[7:1]};  // LSB first
            bit_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (bit_cnt_q == LastCnt) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Receive FIFO and sticky flags.
  logic [7:0]      mem_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0] occ_q, occ_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            stop_sample, full, push, pop, drop, frame_bad;

  always_comb begin
    stop_sample = (state_q == StStop) && (bit_cnt_q == LastCnt);
    full        = (occ_q == FullOcc);
    pop         = bus_io.read_en && (occ_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept the byte.
    push        = stop_sample && rx_s_q && (!full || bus_io.read_en);
    drop        = stop_sample && rx_s_q && full && !bus_io.read_en;
    frame_bad   = stop_sample && !rx_s_q;

    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + 1'b1;
    end else if (pop && !push) begin
      occ_d = occ_q - 1'b1;
    end

    frame_err_d = bus_io.err_clear ? 1'b0 : (frame_err_q | frame_bad);
    overrun_d   = bus_io.err_clear ? 1'b0 : (overrun_q | drop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      occ_q       <= occ_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign bus_io.data       = (occ_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign bus_io.data_valid = (occ_q != '0);
  assign bus_io.fifo_full  = full;
  assign bus_io.frame_err  = frame_err_q;
  assign bus_io.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit and a 4-entry FIFO.
module tb_uart_rx;

  localparam int Cpb   = 16;
  localparam int Depth = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  uart_rx_if bus ();

  uart_rx #(
    .ClksPerBit(Cpb),
    .FifoDepth (Depth)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus)
  );

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic [7:0] exp_head;
    logic       exp_valid;
    logic       exp_full;
    logic       exp_fe;
    logic       exp_ov;
  } vec_t;

  // Reference model: byte queue plus sticky flags, updated per whole frame.
  logic [7:0] model_q[$];
  logic       model_fe;
  logic       model_ov;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_all(input string name, input logic valid, input logic [7:0] head,
                           input logic full, input logic fe, input logic ov);
    chk({name, ".data_valid"}, {7'b0, bus.data_valid}, {7'b0, valid});
    chk({name, ".data"},       bus.data,               head);
    chk({name, ".fifo_full"},  {7'b0, bus.fifo_full},  {7'b0, full});
    chk({name, ".frame_err"},  {7'b0, bus.frame_err},  {7'b0, fe});
    chk({name, ".overrun"},    {7'b0, bus.overrun},    {7'b0, ov});
  endtask

  // Drives one 10-bit frame. At negedge n, exactly n rising edges have passed since the start
  // bit was driven; the stop bit is sampled on edge 154 (mid stop bit plus synchroniser delay).
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit lat,
                            input bit pop_stop, input bit clr_stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int n = 0; n < 10 * Cpb; n++) begin
      @(negedge clk);
      if (lat && n == 154) chk("latency.before", {7'b0, bus.data_valid}, 8'h00);
      if (lat && n == 155) chk("latency.after",  {7'b0, bus.data_valid}, 8'h01);
      bus.rx        = frame[n / Cpb];
      bus.read_en   = pop_stop && (n == 154);
      bus.err_clear = clr_stop && (n == 154);
    end
    @(negedge clk);
    bus.rx        = 1'b1;
    bus.read_en   = 1'b0;
    bus.err_clear = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    @(negedge clk);
    chk({name, ".valid"}, {7'b0, bus.data_valid}, 8'h01);
    chk({name, ".head"},  bus.data,               exp);
    bus.read_en = 1'b1;
    @(negedge clk);
    bus.read_en = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.err_clear = 1'b1;
    @(negedge clk);
    bus.err_clear = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.rx = 1'b1;
    bus.read_en = 1'b0;
    bus.err_clear = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish within time limit, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       tbl[6];
    logic [7:0] rb;
    logic       rstop;
    logic [9:0] ff_frame;

    tbl[0] = '{8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h02, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{8'h03, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{8'h04, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h05, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{8'h3C, 1'b0, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0;
    bus.rx = 1'b1;
    bus.read_en = 1'b0;
    bus.err_clear = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte with exact push latency, then pop back to empty.
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    check_all("single", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    pop_chk("single.pop", 8'hA5);
    check_all("single.empty", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    bus.read_en = 1'b1;
    @(negedge clk);
    bus.read_en = 1'b0;
    check_all("pop_empty", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Fill, overrun, then a framing error on a full FIFO.
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].b, tbl[i].stop, 1'b0, 1'b0, 1'b0);
      check_all($sformatf("tbl%0d", i), tbl[i].exp_valid, tbl[i].exp_head, tbl[i].exp_full,
                tbl[i].exp_fe, tbl[i].exp_ov);
    end
    for (int i = 1; i <= 4; i++) pop_chk($sformatf("drain%0d", i), 8'(i));
    @(negedge clk);
    check_all("drained", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    pulse_clear();
    check_all("cleared", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Framing error with err_clear on the sample cycle: clear wins.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    check_all("fe_clr_prio", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    check_all("frame_err", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    pulse_clear();
    check_all("fe_cleared", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Glitch rejection, then confirm the receiver is still ready.
    @(negedge clk);
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    bus.rx = 1'b1;
    repeat (200) @(negedge clk);
    check_all("glitch", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'h42, 1'b1, 1'b0, 1'b0, 1'b0);
    pop_chk("post_glitch", 8'h42);

    // Push and pop in the same cycle while full.
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h77, 1'b1, 1'b0, 1'b1, 1'b0);
    check_all("pushpop_full", 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
    pop_chk("pp.a", 8'h02);
    pop_chk("pp.b", 8'h03);
    pop_chk("pp.c", 8'h04);
    pop_chk("pp.d", 8'h77);

    // Reset during data bit 3 of 8'hFF with state present.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    ff_frame = {1'b1, 8'hFF, 1'b0};
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      bus.rx = ff_frame[n / Cpb];
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all("midreset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    bus.rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    check_all("after_reset", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);

    // Randomised frames against the queue model.
    do_reset();
    model_q.delete();
    model_fe = 1'b0;
    model_ov = 1'b0;
    for (int t = 0; t < 24; t++) begin
      rb    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 7) != 0);
      send_frame(rb, rstop, 1'b0, 1'b0, 1'b0);
      if (!rstop) model_fe = 1'b1;
      else if (model_q.size() < Depth) model_q.push_back(rb);
      else model_ov = 1'b1;
      check_all($sformatf("rnd%0d", t), model_q.size() != 0,
                (model_q.size() != 0) ? model_q[0] : 8'h00,
                model_q.size() == Depth, model_fe, model_ov);
      for (int p = $urandom_range(0, 2); p > 0; p--) begin
        if (model_q.size() != 0) pop_chk($sformatf("rnd%0d.pop", t), model_q.pop_front());
      end
      if ($urandom_range(0, 3) == 0) begin
        pulse_clear();
        model_fe = 1'b0;
        model_ov = 1'b0;
      end
    end
    @(negedge clk);
    check_all("rnd.end", model_q.size() != 0, (model_q.size() != 0) ? model_q[0] : 8'h00,
              model_q.size() == Depth, model_fe, model_ov);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
